unidade_controle_jogo: RTL and testbench

Moore control unit for the memory-sequence game (exp6). It sits beside the game datapath inside the top-level circuit and sequences it through a game. It zeroes and advances the address (jogada) and round (rodada) counters and commands the play register and the timeout counter. It evaluates comparison, end-of-round, last-round and timeout flags, and reports win, loss or timeout through `pronto`/`ganhou`/`perdeu`.

---
 rtl/jogo_pkg.sv | 19 +
 rtl/unidade_controle_jogo.sv | 118 +++++++++++
 tb/tb_unidade_controle_jogo.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// State width and state codes for the memory-sequence game controller.
// The codes double as the value shown on the hex display via db_estado.
package jogo_pkg;
    localparam int ESTADO_W = 4;

    typedef logic [ESTADO_W-1:0] estado_t;

    localparam estado_t INICIAL        = 4'h0;
    localparam estado_t PREPARACAO     = 4'h1;
    localparam estado_t INICIA_RODADA  = 4'h2;
    localparam estado_t ESPERA_JOGADA  = 4'h3;
    localparam estado_t REGISTRA       = 4'h4;
    localparam estado_t COMPARA        = 4'h5;
    localparam estado_t PROXIMA_JOGADA = 4'h6;
    localparam estado_t PROXIMA_RODADA = 4'h7;
    localparam estado_t FIM_GANHOU     = 4'hA;
    localparam estado_t FIM_PERDEU     = 4'hE;
    localparam estado_t FIM_TIMEOUT    = 4'hD;
endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory-sequence game: sequences the datapath
// counters and play register through rounds and reports win/loss/timeout.
module unidade_controle_jogo
    import jogo_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogada,
    input  logic                igual,
    input  logic                enderecoIgualRodada,
    input  logic                fimRodada,
    input  logic                timeout,
    output logic                zeraE,
    output logic                contaE,
    output logic                zeraR,
    output logic                contaR,
    output logic                zeraT,
    output logic                contaT,
    output logic                registraR,
    output logic                limpaR,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                db_timeout,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t estado, prox_estado;

    // State register; reset is synchronous and overrides everything.
    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= prox_estado;
    end

    // Next-state logic. Unused codes fall back to INICIAL.
    always_comb begin
        prox_estado = INICIAL;
        case (estado)
            INICIAL:        prox_estado = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     prox_estado = INICIA_RODADA;
            INICIA_RODADA:  prox_estado = ESPERA_JOGADA;
            // timeout takes priority over a simultaneous button press
            ESPERA_JOGADA:  prox_estado = timeout ? FIM_TIMEOUT :
                                          jogada  ? REGISTRA    : ESPERA_JOGADA;
            REGISTRA:       prox_estado = COMPARA;
            COMPARA: begin
                if (!igual)
                    prox_estado = FIM_PERDEU;
                else if (enderecoIgualRodada && fimRodada)
                    prox_estado = FIM_GANHOU;
                else if (enderecoIgualRodada)
                    prox_estado = PROXIMA_RODADA;
                else
                    prox_estado = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: prox_estado = ESPERA_JOGADA;
            PROXIMA_RODADA: prox_estado = INICIA_RODADA;
            FIM_GANHOU:     prox_estado = iniciar ? PREPARACAO : FIM_GANHOU;
            FIM_PERDEU:     prox_estado = iniciar ? PREPARACAO : FIM_PERDEU;
            FIM_TIMEOUT:    prox_estado = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:        prox_estado = INICIAL;
        endcase
    end

    // Output decode, a pure function of the current state.
    always_comb begin
        zeraE      = 1'b0;
        contaE     = 1'b0;
        zeraR      = 1'b0;
        contaR     = 1'b0;
        zeraT      = 1'b0;
        contaT     = 1'b0;
        registraR  = 1'b0;
        limpaR     = 1'b0;
        pronto     = 1'b0;
        ganhou     = 1'b0;
        perdeu     = 1'b0;
        db_timeout = 1'b0;
        case (estado)
            PREPARACAO: begin
                zeraE  = 1'b1;
                zeraR  = 1'b1;
                zeraT  = 1'b1;
                limpaR = 1'b1;
            end
            INICIA_RODADA: begin
                zeraE = 1'b1;
                zeraT = 1'b1;
            end
            ESPERA_JOGADA:  contaT    = 1'b1;
            REGISTRA:       registraR = 1'b1;
            PROXIMA_JOGADA: begin
                contaE = 1'b1;
                zeraT  = 1'b1;
            end
            PROXIMA_RODADA: contaR = 1'b1;
            FIM_GANHOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_PERDEU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Scoreboard bench for unidade_controle_jogo: each cycle the expected state
// and output word are queued, a monitor queues what the DUT shows, and each
// scenario task drains and compares both queues.
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada, igual, enderecoIgualRodada, fimRodada, timeout;
    logic       zeraE, contaE, zeraR, contaR, zeraT, contaT, registraR, limpaR;
    logic       pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    // {state, zeraE, contaE, zeraR, contaR, zeraT, contaT, registraR, limpaR,
    //  pronto, ganhou, perdeu, db_timeout}
    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];

    unidade_controle_jogo dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .enderecoIgualRodada(enderecoIgualRodada),
        .fimRodada(fimRodada), .timeout(timeout),
        .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR), .contaR(contaR),
        .zeraT(zeraT), .contaT(contaT), .registraR(registraR), .limpaR(limpaR),
        .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
        .db_timeout(db_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Expected output word for a state code, straight from the state table.
    function automatic logic [15:0] modelo(input logic [3:0] st);
        logic [11:0] o;
        case (st)
            4'h1:    o = 12'b1010_1001_0000; // zeraE zeraR zeraT limpaR
            4'h2:    o = 12'b1000_1000_0000; // zeraE zeraT
            4'h3:    o = 12'b0000_0100_0000; // contaT
            4'h4:    o = 12'b0000_0010_0000; // registraR
            4'h6:    o = 12'b0100_1000_0000; // contaE zeraT
            4'h7:    o = 12'b0001_0000_0000; // contaR
            4'hA:    o = 12'b0000_0000_1100; // pronto ganhou
            4'hE:    o = 12'b0000_0000_1010; // pronto perdeu
            4'hD:    o = 12'b0000_0000_1011; // pronto perdeu db_timeout
            default: o = 12'b0;
        endcase
        return {st, o};
    endfunction

    // Monitor: capture DUT state/outputs just after each active edge.
    always @(posedge clock) begin
        #1;
        if (mon_en)
            act_q.push_back({db_estado, zeraE, contaE, zeraR, contaR, zeraT, contaT,
                             registraR, limpaR, pronto, ganhou, perdeu, db_timeout});
    end

    // Advance one edge, queueing the state expected after it.
    task automatic tick(input logic [3:0] st);
        @(posedge clock);
        exp_q.push_back(modelo(st));
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        iniciar = 0; jogada = 0; igual = 0; enderecoIgualRodada = 0;
        fimRodada = 0; timeout = 0;
    endtask

    task automatic test_reset();
        logic [15:0] e, a;
        reset = 1; clear_inputs(); iniciar = 1;
        @(negedge clock);
        mon_en = 1'b1;
        tick(4'h0); tick(4'h0); tick(4'h0);
        reset = 0; iniciar = 0;
        tick(4'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_q.size() == 0) begin
                errors++; $display("FAIL reset: no sample, expected %h", e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++; $display("FAIL reset: got %h expected %h", a, e);
                end
            end
        end
    endtask

    task automatic test_start();
        logic [15:0] e, a;
        iniciar = 1;
        tick(4'h1); tick(4'h2); tick(4'h3); tick(4'h3); tick(4'h3);
        iniciar = 0;
        tick(4'h3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_q.size() == 0) begin
                errors++; $display("FAIL start: no sample, expected %h", e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++; $display("FAIL start: got %h expected %h", a, e);
                end
            end
        end
    endtask

    // Round advance, one mid-round play, then reset in espera_jogada.
    task automatic test_round_advance();
        logic [15:0] e, a;
        igual = 1; enderecoIgualRodada = 1; fimRodada = 0;
        jogada = 1; tick(4'h4);
        jogada = 0; tick(4'h5); tick(4'h7); tick(4'h2); tick(4'h3);
        enderecoIgualRodada = 0;
        jogada = 1; tick(4'h4);
        jogada = 1; tick(4'h5);          // pulse outside espera_jogada is dropped
        jogada = 0; tick(4'h6); tick(4'h3);
        reset = 1; iniciar = 1;
        tick(4'h0); tick(4'h0);
        reset = 0; iniciar = 0;
        tick(4'h0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_q.size() == 0) begin
                errors++; $display("FAIL round_advance: no sample, expected %h", e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++; $display("FAIL round_advance: got %h expected %h", a, e);
                end
            end
        end
    endtask

    task automatic test_perdeu();
        logic [15:0] e, a;
        iniciar = 1; tick(4'h1);
        iniciar = 0; tick(4'h2); tick(4'h3);
        igual = 1; enderecoIgualRodada = 1;
        for (int r = 0; r < 2; r++) begin
            jogada = 1; tick(4'h4);
            jogada = 0; tick(4'h5); tick(4'h7); tick(4'h2); tick(4'h3);
        end
        enderecoIgualRodada = 0;
        jogada = 1; tick(4'h4);
        jogada = 0; tick(4'h5); tick(4'h6); tick(4'h3);
        igual = 0;
        jogada = 1; tick(4'h4);
        jogada = 0; tick(4'h5); tick(4'hE);
        for (int i = 0; i < 20; i++) begin
            jogada = i[0]; timeout = i[1];
            tick(4'hE);
        end
        jogada = 0; timeout = 0;
        iniciar = 1; tick(4'h1);
        iniciar = 0; tick(4'h2); tick(4'h3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_q.size() == 0) begin
                errors++; $display("FAIL perdeu: no sample, expected %h", e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++; $display("FAIL perdeu: got %h expected %h", a, e);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [15:0] e, a;
        igual = 1;
        timeout = 1; jogada = 1; tick(4'hD);
        timeout = 0; jogada = 0;
        tick(4'hD); tick(4'hD);
        iniciar = 1; tick(4'h1);
        iniciar = 0; tick(4'h2); tick(4'h3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_q.size() == 0) begin
                errors++; $display("FAIL timeout: no sample, expected %h", e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++; $display("FAIL timeout: got %h expected %h", a, e);
                end
            end
        end
    endtask

    task automatic test_ganhou();
        logic [15:0] e, a;
        igual = 1; enderecoIgualRodada = 1; fimRodada = 1;
        jogada = 1; tick(4'h4);
        jogada = 0; tick(4'h5); tick(4'hA); tick(4'hA); tick(4'hA);
        iniciar = 1;
        tick(4'h1); tick(4'h2); tick(4'h3); tick(4'h3);
        clear_inputs();
        tick(4'h3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_q.size() == 0) begin
                errors++; $display("FAIL ganhou: no sample, expected %h", e);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++; $display("FAIL ganhou: got %h expected %h", a, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_round_advance();
        test_perdeu();
        test_timeout();
        test_ganhou();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1, "watchdog");
    end

endmodule
